// File: rtl/block_move_pkg.sv
// Shared constants, direction encoding and axis-step helper for the bouncing block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package block_move_pkg;

    localparam logic [23:0] BG_COLOR     = 24'hFFFFFF;
    localparam logic [23:0] BLOCK_COLOR  = 24'h000000;
    localparam logic [23:0] BORDER_COLOR = 24'hFF0000;
    localparam int          BORDER_W     = 10;

    // Bit 0 set = moving left, bit 1 set = moving up.
    typedef enum logic [1:0] {
        DIR_DR = 2'b00,
        DIR_DL = 2'b01,
        DIR_UR = 2'b10,
        DIR_UL = 2'b11
    } dir_t;

    // One axis step with clamping; 12-bit math so neither end can wrap.
    function automatic logic [11:0] step_axis(
        input logic [11:0] pos,
        input logic        fwd,
        input logic [11:0] step,
        input logic [11:0] lo,
        input logic [11:0] hi
    );
        logic [11:0] res;
        if (fwd) begin
            res = pos + step;
            if (res > hi) res = hi;
        end else begin
            if (pos < lo + step) res = lo;
            else                 res = pos - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/block_move_gen_frame_tick.sv
// Detects video_vs falling edges and divides them down into block move enables.
// Latency: frame_tick and move_en are registered, one cycle after the edge is seen.
// Backpressure: none; pause freezes the divider so no move is lost or gained.
module frame_tick_gen
    import block_move_pkg::*;
#(
    parameter int MOVE_DIV = 1
) (
    input  logic pixel_clk,
    input  logic sys_rst,
    input  logic video_vs,
    input  logic pause,
    output logic frame_tick,
    output logic move_en
);

    localparam logic [7:0] DIV_LAST = 8'(MOVE_DIV - 1);

    logic       vs_prev;
    logic [7:0] div_cnt;
    logic       vs_fall;

    assign vs_fall = vs_prev & ~video_vs;

    // Edge detect and frame divider; move_en fires on the tick that wraps the divider.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            vs_prev    <= 1'b1;
            frame_tick <= 1'b0;
            move_en    <= 1'b0;
            div_cnt    <= 8'd0;
        end else begin
            vs_prev    <= video_vs;
            frame_tick <= vs_fall;
            move_en    <= 1'b0;
            if (vs_fall && !pause) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= 8'd0;
                    move_en <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/block_move_gen.sv
// Bouncing square block pattern generator; optional screen border when BORDER_EN is defined.
// Latency: pixel_data is registered, 1 cycle after pixel_xpos/pixel_ypos.
// Backpressure: none; the position moves only on frame ticks (inside vsync), pause holds it.
module block_move_gen
    import block_move_pkg::*;
#(
    parameter int H_DISP   = 1280,
    parameter int V_DISP   = 720,
    parameter int BLOCK_W  = 40,
    parameter int STEP     = 1,
    parameter int MOVE_DIV = 1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic        video_vs,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic        pause,
    output logic [23:0] pixel_data,
    output logic        frame_tick
);

`ifdef BORDER_EN
    localparam int LO = BORDER_W;
`else
    localparam int LO = 0;
`endif

    localparam logic [11:0] X_MIN  = 12'(LO);
    localparam logic [11:0] X_MAX  = 12'(H_DISP - BLOCK_W - LO);
    localparam logic [11:0] Y_MIN  = 12'(LO);
    localparam logic [11:0] Y_MAX  = 12'(V_DISP - BLOCK_W - LO);
    localparam logic [11:0] STEP_W = 12'(STEP);
    localparam logic [11:0] BLK_W  = 12'(BLOCK_W);

    logic        move_en;
    logic [11:0] block_x;
    logic [11:0] block_y;
    dir_t        dir;

    logic        go_right;
    logic        go_down;
    logic [11:0] next_x;
    logic [11:0] next_y;
    logic        hit_x;
    logic        hit_y;
    logic [11:0] px;
    logic [11:0] py;
    logic        in_block;

    frame_tick_gen #(
        .MOVE_DIV (MOVE_DIV)
    ) u_frame_tick_gen (
        .pixel_clk  (pixel_clk),
        .sys_rst    (sys_rst),
        .video_vs   (video_vs),
        .pause      (pause),
        .frame_tick (frame_tick),
        .move_en    (move_en)
    );

    // Candidate next position and which limits it lands on in the direction of travel.
    always_comb begin
        go_right = (dir == DIR_DR) || (dir == DIR_UR);
        go_down  = (dir == DIR_DR) || (dir == DIR_DL);
        next_x   = step_axis(block_x, go_right, STEP_W, X_MIN, X_MAX);
        next_y   = step_axis(block_y, go_down,  STEP_W, Y_MIN, Y_MAX);
        hit_x    = go_right ? (next_x == X_MAX) : (next_x == X_MIN);
        hit_y    = go_down  ? (next_y == Y_MAX) : (next_y == Y_MIN);
    end

    // Direction FSM and position registers; a corner flips both components at once.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            block_x <= X_MIN;
            block_y <= Y_MIN;
            dir     <= DIR_DR;
        end else if (move_en && !pause) begin
            block_x <= next_x;
            block_y <= next_y;
            case (dir)
                DIR_DR: dir <= (hit_x && hit_y) ? DIR_UL : hit_x ? DIR_DL : hit_y ? DIR_UR : DIR_DR;
                DIR_DL: dir <= (hit_x && hit_y) ? DIR_UR : hit_x ? DIR_DR : hit_y ? DIR_UL : DIR_DL;
                DIR_UR: dir <= (hit_x && hit_y) ? DIR_DL : hit_x ? DIR_UL : hit_y ? DIR_DR : DIR_UR;
                DIR_UL: dir <= (hit_x && hit_y) ? DIR_DR : hit_x ? DIR_UR : hit_y ? DIR_DL : DIR_UL;
                default: dir <= DIR_DR;
            endcase
        end
    end

    assign px = {1'b0, pixel_xpos};
    assign py = {1'b0, pixel_ypos};
    assign in_block = (px >= block_x) && (px < block_x + BLK_W) &&
                      (py >= block_y) && (py < block_y + BLK_W);

`ifdef BORDER_EN
    localparam logic [11:0] BRD_LO   = 12'(BORDER_W);
    localparam logic [11:0] BRD_X_HI = 12'(H_DISP - BORDER_W);
    localparam logic [11:0] BRD_Y_HI = 12'(V_DISP - BORDER_W);

    logic in_border;
    assign in_border = (px < BRD_LO) || (px >= BRD_X_HI) ||
                       (py < BRD_LO) || (py >= BRD_Y_HI);

    // Registered colour lookup; border wins over the block.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst)        pixel_data <= 24'd0;
        else if (in_border) pixel_data <= BORDER_COLOR;
        else if (in_block)  pixel_data <= BLOCK_COLOR;
        else                pixel_data <= BG_COLOR;
    end
`else
    // Registered colour lookup: block over background.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst)       pixel_data <= 24'd0;
        else if (in_block) pixel_data <= BLOCK_COLOR;
        else               pixel_data <= BG_COLOR;
    end
`endif

endmodule

// File: tb/tb_block_move_gen.sv
// Randomized scoreboard bench for block_move_gen with a behavioural bounce model.
// Latency: expects pixel_data one cycle after each requested coordinate.
// Backpressure: n/a.
module tb_block_move_gen;

    localparam int H    = 1280;
    localparam int V    = 720;
    localparam int BLK  = 40;
    localparam int STP  = 1;
`ifdef BORDER_EN
    localparam int LO   = 10;
`else
    localparam int LO   = 0;
`endif
    localparam int XMIN = LO;
    localparam int XMAX = H - BLK - LO;
    localparam int YMIN = LO;
    localparam int YMAX = V - BLK - LO;

    localparam logic [23:0] C_BG     = 24'hFFFFFF;
    localparam logic [23:0] C_BLOCK  = 24'h000000;
    localparam logic [23:0] C_BORDER = 24'hFF0000;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        video_vs = 1'b1;
    logic [10:0] xpos = 11'd0;
    logic [10:0] ypos = 11'd0;
    logic        pause = 1'b0;
    logic [23:0] pixel_data;
    logic        frame_tick;

    logic        req = 1'b0;
    logic        req_q = 1'b0;
    logic [23:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: position and per-axis direction (+1 / -1).
    int mbx, mby, mdx, mdy;

    block_move_gen #(
        .H_DISP   (H),
        .V_DISP   (V),
        .BLOCK_W  (BLK),
        .STEP     (STP),
        .MOVE_DIV (1)
    ) dut (
        .pixel_clk  (clk),
        .sys_rst    (sys_rst),
        .video_vs   (video_vs),
        .pixel_xpos (xpos),
        .pixel_ypos (ypos),
        .pause      (pause),
        .pixel_data (pixel_data),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) req_q <= req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (model block %0d,%0d)", name, act, exp, mbx, mby);
        end
    endtask

    function automatic logic [23:0] model_pixel(input int x, input int y);
`ifdef BORDER_EN
        if (x < 10 || x >= H - 10 || y < 10 || y >= V - 10) return C_BORDER;
`endif
        if (x >= mbx && x < mbx + BLK && y >= mby && y < mby + BLK) return C_BLOCK;
        return C_BG;
    endfunction

    task automatic model_reset();
        mbx = XMIN; mby = YMIN; mdx = 1; mdy = 1;
    endtask

    task automatic model_move();
        if (mdx > 0) begin
            mbx = mbx + STP;
            if (mbx >= XMAX) begin mbx = XMAX; mdx = -1; end
        end else begin
            mbx = mbx - STP;
            if (mbx <= XMIN) begin mbx = XMIN; mdx = 1; end
        end
        if (mdy > 0) begin
            mby = mby + STP;
            if (mby >= YMAX) begin mby = YMAX; mdy = -1; end
        end else begin
            mby = mby - STP;
            if (mby <= YMIN) begin mby = YMIN; mdy = 1; end
        end
    endtask

    // Monitor: every registered request produces one pixel compared against the queue head.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (req_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_unexpected actual=%h expected=none", pixel_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {8'd0, pixel_data}, {8'd0, e});
                end
            end
        end
    end

    task automatic probe(input int x, input int y);
        @(posedge clk); #1;
        xpos = 11'(x);
        ypos = 11'(y);
        req  = 1'b1;
        exp_q.push_back(model_pixel(x, y));
        @(posedge clk); #1;
        req  = 1'b0;
    endtask

    // Probe the block corners and the pixels just outside it.
    task automatic check_pos();
        probe(mbx, mby);
        probe(mbx + BLK - 1, mby + BLK - 1);
        if (mbx + BLK < H) probe(mbx + BLK, mby);
        if (mby + BLK < V) probe(mbx, mby + BLK);
        if (mbx > 0) probe(mbx - 1, mby);
        if (mby > 0) probe(mbx, mby - 1);
    endtask

    // One video_vs falling edge; frame_tick must pulse for exactly the following cycle.
    task automatic vs_edge();
        @(posedge clk); #1;
        check("tick_idle", {31'd0, frame_tick}, 32'd0);
        video_vs = 1'b0;
        @(posedge clk); #1;
        check("tick_pulse", {31'd0, frame_tick}, 32'd1);
        video_vs = 1'b1;
        if (!pause) model_move();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bounce_seen;

        // Reset held for three cycles.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel", {8'd0, pixel_data}, 32'd0);
        check("rst_tick", {31'd0, frame_tick}, 32'd0);
        sys_rst = 1'b0;

        // Reset position, latency and block edges.
        probe(0, 0);
        probe(LO + 39, LO);
        probe(LO + 40, LO);
        probe(LO, LO + 40);
`ifdef BORDER_EN
        probe(5, 300);
        probe(H - 1, 0);
`endif
        check_pos();

        // First move, then five paused edges.
        vs_edge();
        check_pos();
        pause = 1'b1;
        repeat (5) vs_edge();
        check_pos();
        pause = 1'b0;

`ifndef BORDER_EN
        // Run to the right-edge bounce, then on to the corner.
        bounce_seen = 1'b0;
        n = 0;
        while (!(mbx == XMAX && mby == YMAX) && n < 22000) begin
            vs_edge();
            n++;
            if (!bounce_seen && mbx == XMAX) begin
                bounce_seen = 1'b1;
                check_pos();
                vs_edge();
                n++;
                check_pos();
            end
        end
        check("corner_reached", {31'd0, (mbx == XMAX && mby == YMAX)}, 32'd1);
        check_pos();
        vs_edge();
        check_pos();
`endif

        // Reset in the middle of an update: the pending move is discarded.
        @(posedge clk); #1;
        video_vs = 1'b0;
        @(posedge clk); #1;
        sys_rst  = 1'b1;
        video_vs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sys_rst = 1'b0;
        model_reset();
        check_pos();
        vs_edge();
        check_pos();

        // Randomized pause, idle gaps and probes.
        for (int i = 0; i < 150; i++) begin
            pause = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            vs_edge();
            pause = 1'b0;
            for (int k = 0; k < 3; k++) begin
                int x, y;
                if ($urandom_range(0, 1) == 1) begin
                    x = mbx + $urandom_range(0, BLK + 1) - 1;
                    y = mby + $urandom_range(0, BLK + 1) - 1;
                    if (x < 0) x = 0;
                    if (y < 0) y = 0;
                    if (x > H - 1) x = H - 1;
                    if (y > V - 1) y = V - 1;
                end else begin
                    x = $urandom_range(0, H - 1);
                    y = $urandom_range(0, V - 1);
                end
                probe(x, y);
            end
        end

        repeat (3) @(posedge clk);
        check("queue_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
